// File: rtl/fletcher_pkg.sv
// rtl/fletcher_pkg.sv - shared state encoding and arithmetic helpers for the Fletcher checksum engine
package fletcher_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FINAL = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam int MaxH     = 32;
  localparam int MaxBytes = MaxH / 8;

  // Folds bit h of an (h+1)-bit sum back into bit 0; the result may be all-ones (== 0 mod 2^h-1).
  function automatic logic [MaxH-1:0] mod_reduce(input logic [MaxH:0] sum, input int unsigned h);
    logic [MaxH-1:0] low;
    logic            carry;
    low   = sum[MaxH-1:0] & ~({MaxH{1'b1}} << h);
    carry = sum[h];
    return low + MaxH'(carry);
  endfunction

  function automatic logic [3:0] eff_bytes(input logic [3:0] bytes, input logic [3:0] nbytes);
    return (bytes == 4'd0 || bytes > nbytes) ? nbytes : bytes;
  endfunction

  function automatic logic [MaxBytes-1:0] lane_mask(input logic [3:0] bytes, input logic [3:0] nbytes);
    logic [3:0]          eff;
    logic [MaxBytes-1:0] m;
    eff = eff_bytes(bytes, nbytes);
    for (int i = 0; i < MaxBytes; i++) begin
      m[i] = (4'(i) < eff);
    end
    return m;
  endfunction

endpackage

// File: rtl/fletcher_checksum_stream_if.sv
// rtl/fletcher_checksum_stream_if.sv - data-in / result-out handshake bundle for the checksum engine
interface fletcher_checksum_stream_if #(
  parameter int Width    = 32,
  parameter int LenWidth = 32
);
  localparam int H  = Width / 2;
  localparam int BW = $clog2(H / 8) + 1;

  logic                in_valid;
  logic                in_ready;
  logic [H-1:0]        in_data;
  logic                in_last;
  logic [BW-1:0]       in_bytes;
  logic [Width-1:0]    exp;
  logic                out_valid;
  logic                out_ready;
  logic [Width-1:0]    out_sum;
  logic                out_match;
  logic [LenWidth-1:0] out_len;

  modport master (
    output in_valid, in_data, in_last, in_bytes, exp, out_ready,
    input  in_ready, out_valid, out_sum, out_match, out_len
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, exp, out_ready,
    output in_ready, out_valid, out_sum, out_match, out_len
  );
endinterface

// File: rtl/fletcher_modadd.sv
// rtl/fletcher_modadd.sv - H-bit ones'-complement adder (end-around carry, modulus 2^H-1)
module fletcher_modadd
  import fletcher_pkg::*;
#(
  parameter int H = 16
) (
  input  logic [H-1:0] a_i,
  input  logic [H-1:0] b_i,
  output logic [H-1:0] sum_o
);

  logic [MaxH:0] raw;

  assign raw   = (MaxH+1)'(a_i) + (MaxH+1)'(b_i);
  assign sum_o = H'(mod_reduce(raw, H));

endmodule

// File: rtl/fletcher_checksum_stream.sv
// rtl/fletcher_checksum_stream.sv - streaming Fletcher-N checksum with partial last word and compare
module fletcher_checksum_stream
  import fletcher_pkg::*;
#(
  parameter int Width    = 32,
  parameter int LenWidth = 32
) (
  input  logic                        clk,
  input  logic                        rst_,
  input  logic                        clr,
  fletcher_checksum_stream_if.slave   bus
);

  localparam int H  = Width / 2;
  localparam int NB = H / 8;
  localparam logic [H-1:0] Ones = '1;

  state_e              state_q, state_d;
  logic [H-1:0]        a_q, a_d, b_q, b_d;
  logic [H-1:0]        pd_q, pd_d;
  logic                pv_q, pv_d, plast_q, plast_d;
  logic [3:0]          pinc_q, pinc_d;
  logic [LenWidth-1:0] len_q, len_d, olen_q, olen_d;
  logic [Width-1:0]    sum_q, sum_d;
  logic                match_q, match_d;

  logic [H-1:0]        a_new, b_new;
  logic [H-1:0]        data_mask;
  logic [NB-1:0]       lanes;
  logic [3:0]          bytes_eff;
  logic [LenWidth:0]   len_sum;
  logic                in_ready, out_valid, accept;

  // Accepted words are staged one cycle before entering the adders.
  fletcher_modadd #(.H(H)) u_add_a (.a_i(a_q), .b_i(pd_q),  .sum_o(a_new));
  fletcher_modadd #(.H(H)) u_add_b (.a_i(b_q), .b_i(a_new), .sum_o(b_new));

  assign len_sum = {1'b0, len_q} + (LenWidth+1)'(pinc_q);

  always_comb begin
    data_mask = '0;
    bytes_eff = 4'(NB);
    lanes     = '1;
    if (bus.in_last) begin
      bytes_eff = eff_bytes(4'(bus.in_bytes), 4'(NB));
      lanes     = NB'(lane_mask(4'(bus.in_bytes), 4'(NB)));
    end
    for (int i = 0; i < NB; i++) begin
      data_mask[8*i +: 8] = {8{lanes[i]}};
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    len_d     = len_q;
    pv_d      = 1'b0;
    pd_d      = pd_q;
    plast_d   = plast_q;
    pinc_d    = pinc_q;
    sum_d     = sum_q;
    match_d   = match_q;
    olen_d    = olen_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;

    case (state_q)
      ACCUM: begin
        in_ready = !(pv_q && plast_q);
        accept   = bus.in_valid && in_ready;
        if (accept) begin
          pv_d    = 1'b1;
          pd_d    = bus.in_data & data_mask;
          plast_d = bus.in_last;
          pinc_d  = bytes_eff;
        end
        if (pv_q) begin
          a_d   = a_new;
          b_d   = b_new;
          len_d = len_sum[LenWidth] ? '1 : len_sum[LenWidth-1:0];
          if (plast_q) state_d = FINAL;
        end
      end
      FINAL: begin
        sum_d   = {(b_q == Ones) ? '0 : b_q, (a_q == Ones) ? '0 : a_q};
        match_d = (sum_d == bus.exp);
        olen_d  = len_q;
        state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          a_d     = '0;
          b_d     = '0;
          len_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    if (clr) begin
      state_d = ACCUM;
      a_d     = '0;
      b_d     = '0;
      len_d   = '0;
      pv_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ACCUM;
      a_q     <= '0;
      b_q     <= '0;
      len_q   <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
      plast_q <= 1'b0;
      pinc_q  <= '0;
      sum_q   <= '0;
      match_q <= 1'b0;
      olen_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      len_q   <= len_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
      plast_q <= plast_d;
      pinc_q  <= pinc_d;
      sum_q   <= sum_d;
      match_q <= match_d;
      olen_q  <= olen_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = sum_q;
  assign bus.out_match = match_q;
  assign bus.out_len   = olen_q;

endmodule

// File: tb/tb_fletcher_checksum_stream.sv
// tb/tb_fletcher_checksum_stream.sv - directed and model-checked bench for Fletcher-16/32/64
module tb_fletcher_checksum_stream;

  typedef byte unsigned bq_t[$];

  logic clk = 1'b0;
  logic rst_;
  logic clr;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fletcher_checksum_stream_if #(.Width(16), .LenWidth(8))  if16 ();
  fletcher_checksum_stream_if #(.Width(32), .LenWidth(32)) if32 ();
  fletcher_checksum_stream_if #(.Width(64), .LenWidth(32)) if64 ();

  fletcher_checksum_stream #(.Width(16), .LenWidth(8))  u_dut16 (.clk(clk), .rst_(rst_), .clr(clr), .bus(if16));
  fletcher_checksum_stream #(.Width(32), .LenWidth(32)) u_dut32 (.clk(clk), .rst_(rst_), .clr(clr), .bus(if32));
  fletcher_checksum_stream #(.Width(64), .LenWidth(32)) u_dut64 (.clk(clk), .rst_(rst_), .clr(clr), .bus(if64));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic set_in(input int w, input logic v, input logic [31:0] d, input logic last, input logic [2:0] nb);
    case (w)
      16: begin if16.in_valid = v; if16.in_data = d[7:0];  if16.in_last = last; if16.in_bytes = nb[0];   end
      32: begin if32.in_valid = v; if32.in_data = d[15:0]; if32.in_last = last; if32.in_bytes = nb[1:0]; end
      default: begin if64.in_valid = v; if64.in_data = d; if64.in_last = last; if64.in_bytes = nb; end
    endcase
  endtask

  task automatic set_exp(input int w, input logic [63:0] v);
    case (w)
      16: if16.exp = v[15:0];
      32: if32.exp = v[31:0];
      default: if64.exp = v;
    endcase
  endtask

  task automatic set_oready(input int w, input logic v);
    case (w)
      16: if16.out_ready = v;
      32: if32.out_ready = v;
      default: if64.out_ready = v;
    endcase
  endtask

  function automatic logic get_ready(input int w);
    case (w)
      16: return if16.in_ready;
      32: return if32.in_ready;
      default: return if64.in_ready;
    endcase
  endfunction

  function automatic logic get_ovalid(input int w);
    case (w)
      16: return if16.out_valid;
      32: return if32.out_valid;
      default: return if64.out_valid;
    endcase
  endfunction

  function automatic logic [63:0] get_sum(input int w);
    case (w)
      16: return 64'(if16.out_sum);
      32: return 64'(if32.out_sum);
      default: return if64.out_sum;
    endcase
  endfunction

  function automatic logic get_match(input int w);
    case (w)
      16: return if16.out_match;
      32: return if32.out_match;
      default: return if64.out_match;
    endcase
  endfunction

  function automatic logic [63:0] get_len(input int w);
    case (w)
      16: return 64'(if16.out_len);
      32: return 64'(if32.out_len);
      default: return 64'(if64.out_len);
    endcase
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic logic [63:0] model_sum(input int w, input bq_t msg);
    int h = w / 2;
    longint unsigned m = (64'd1 << h) - 1;
    longint unsigned a = 0, b = 0, d;
    for (int i = 0; i < msg.size(); i += h / 8) begin
      d = 0;
      for (int j = 0; j < h / 8; j++)
        if (i + j < msg.size()) d |= longint'(msg[i+j]) << (8 * j);
      a = (a + d) % m;
      b = (b + a) % m;
    end
    return (b << h) | a;
  endfunction

  function automatic logic [63:0] model_len(input int w, input int n);
    longint unsigned lim = (w == 16) ? 64'd255 : 64'hFFFF_FFFF;
    return (longint'(n) > lim) ? lim : 64'(n);
  endfunction

  // All driving happens 1 time unit after a rising edge.
  task automatic put_word(input int w, input logic [31:0] d, input logic last, input logic [2:0] nb);
    bit done = 0;
    set_in(w, 1'b1, d, last, nb);
    for (int i = 0; i < 50 && !done; i++) begin
      done = get_ready(w);
      @(posedge clk); #1;
    end
    set_in(w, 1'b0, 32'h0, 1'b0, 3'd0);
    if (!done) check_eq("put_word_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_msg(input int w, input bq_t msg, input bit gaps);
    int nb = w / 16;
    int n  = msg.size();
    int i  = 0;
    while (i < n) begin
      logic [31:0] d;
      int take;
      d    = 32'hAAAA_AAAA;
      take = (n - i < nb) ? n - i : nb;
      for (int j = 0; j < take; j++) d[8*j +: 8] = msg[i+j];
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      put_word(w, d, (i + take == n), 3'(take));
      i += take;
    end
  endtask

  task automatic wait_valid(input int w, input string tag);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = get_ovalid(w);
      if (!ok) begin @(posedge clk); #1; end
    end
    check_eq({tag, "_valid"}, 64'(ok), 64'd1);
  endtask

  task automatic pop(input int w, input string tag);
    set_oready(w, 1'b1);
    @(posedge clk); #1;
    set_oready(w, 1'b0);
    check_eq({tag, "_ready_after"}, 64'(get_ready(w)), 64'd1);
  endtask

  task automatic run_msg(input int w, input bq_t msg, input logic [63:0] expv,
                         input logic [63:0] want, input bit gaps, input string tag);
    set_exp(w, expv);
    send_msg(w, msg, gaps);
    wait_valid(w, tag);
    check_eq({tag, "_sum"},   get_sum(w), want);
    check_eq({tag, "_len"},   get_len(w), model_len(w, msg.size()));
    check_eq({tag, "_match"}, 64'(get_match(w)), 64'(expv == want));
    pop(w, tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bq_t msg;
    logic [63:0] want;
    rst_ = 1'b0;
    clr  = 1'b0;
    foreach (msg[i]) msg[i] = 0;
    for (int w = 16; w <= 64; w *= 2) begin
      set_in(w, 1'b0, 32'h0, 1'b0, 3'd0);
      set_exp(w, 64'h0);
      set_oready(w, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  64'(get_ready(32)),  64'd1);
    check_eq("rst_out_valid", 64'(get_ovalid(32)), 64'd0);
    check_eq("rst_out_sum",   get_sum(64),         64'd0);
    check_eq("rst_out_match", 64'(get_match(16)),  64'd0);
    check_eq("rst_out_len",   get_len(32),         64'd0);
    rst_ = 1'b1;
    @(posedge clk); #1;

    // Fletcher-16 "abcde" with the latency profile of the final word
    set_exp(16, 64'hC8F0);
    send_msg(16, str2q("abcde"), 1'b0);
    check_eq("t1_ready_k",  64'(get_ready(16)),  64'd0);
    @(posedge clk); #1;
    check_eq("t1_valid_k1", 64'(get_ovalid(16)), 64'd0);
    @(posedge clk); #1;
    check_eq("t1_valid_k2", 64'(get_ovalid(16)), 64'd1);
    check_eq("t1_sum",      get_sum(16),         64'hC8F0);
    check_eq("t1_len",      get_len(16),         64'd5);
    check_eq("t1_match",    64'(get_match(16)),  64'd1);
    check_eq("t1_ready_k2", 64'(get_ready(16)),  64'd0);
    set_oready(16, 1'b1);
    @(posedge clk); #1;
    check_eq("t1_ready_k3", 64'(get_ready(16)),  64'd1);
    check_eq("t1_valid_k3", 64'(get_ovalid(16)), 64'd0);
    set_oready(16, 1'b0);

    // Fletcher-32 "abcde" with 0xAA pad in the unused upper byte
    run_msg(32, str2q("abcde"), 64'hF04F_C729, 64'hF04F_C729, 1'b0, "t2");

    // in_bytes 0 and out-of-range are both taken as a full word
    set_exp(32, 64'h0);
    put_word(32, 32'h6261, 1'b0, 3'd2);
    put_word(32, 32'h6463, 1'b1, 3'd0);
    wait_valid(32, "t2b");
    check_eq("t2b_sum", get_sum(32), 64'h2926_C6C4);
    check_eq("t2b_len", get_len(32), 64'd4);
    pop(32, "t2b");
    put_word(32, 32'h6261, 1'b0, 3'd2);
    put_word(32, 32'h6463, 1'b1, 3'd3);
    wait_valid(32, "t2c");
    check_eq("t2c_sum", get_sum(32), 64'h2926_C6C4);
    check_eq("t2c_len", get_len(32), 64'd4);
    pop(32, "t2c");

    // gapped input, result held while out_ready stays low
    set_exp(32, 64'hEBE1_9591);
    send_msg(32, str2q("abcdefgh"), 1'b1);
    wait_valid(32, "t3");
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_sum_hold",   get_sum(32),         64'hEBE1_9591);
      check_eq("t3_valid_hold", 64'(get_ovalid(32)), 64'd1);
      check_eq("t3_ready_low",  64'(get_ready(32)),  64'd0);
      @(posedge clk); #1;
    end
    check_eq("t3_match", 64'(get_match(32)), 64'd1);
    check_eq("t3_len",   get_len(32),         64'd8);
    pop(32, "t3");
    check_eq("t3_sum_after_pop", get_sum(32), 64'hEBE1_9591);

    // Fletcher-64 "abcde", expected value mismatching
    run_msg(64, str2q("abcde"), 64'h0, 64'hC8C6_C527_6463_62C6, 1'b0, "t4");

    // 255 words of 0xFF: both halves end up all-ones and canonicalise to 0
    msg = {};
    repeat (255) msg.push_back(8'hFF);
    run_msg(16, msg, 64'h0, 64'h0, 1'b0, "t5_ff");

    // length counter saturation on the 8-bit length instance
    msg = {};
    repeat (300) msg.push_back(8'($urandom_range(0, 255)));
    run_msg(16, msg, 64'h1, model_sum(16, msg), 1'b0, "t5_sat");

    for (int w = 16; w <= 64; w *= 2) begin
      for (int k = 0; k < 3; k++) begin
        msg = {};
        repeat ($urandom_range(1, 700)) msg.push_back(8'($urandom_range(0, 255)));
        want = model_sum(w, msg);
        run_msg(w, msg, (k == 1) ? want ^ 64'h1 : want, want, k[0], "t5_rand");
      end
    end
    msg = {};
    repeat (4096) msg.push_back(8'($urandom_range(0, 255)));
    run_msg(32, msg, 64'h0, model_sum(32, msg), 1'b0, "t5_4096");

    // clr after three words discards them
    put_word(16, 32'h11, 1'b0, 3'd1);
    put_word(16, 32'h22, 1'b0, 3'd1);
    put_word(16, 32'h33, 1'b0, 3'd1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    run_msg(16, str2q("abcde"), 64'hC8F0, 64'hC8F0, 1'b0, "t6_clr");

    // asynchronous reset while a result is presented
    set_exp(32, 64'h0);
    send_msg(32, str2q("abcdefgh"), 1'b0);
    wait_valid(32, "t6_rst");
    @(negedge clk); #2;
    rst_ = 1'b0;
    #1;
    check_eq("t6_rst_valid", 64'(get_ovalid(32)), 64'd0);
    check_eq("t6_rst_sum",   get_sum(32),         64'd0);
    check_eq("t6_rst_len",   get_len(32),         64'd0);
    check_eq("t6_rst_match", 64'(get_match(32)),  64'd0);
    check_eq("t6_rst_ready", 64'(get_ready(32)),  64'd1);
    @(posedge clk); #1;
    rst_ = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
